// File: rtl/segment7_pkg.sv
// Shared definitions for the seven-segment display blocks.
// Glyphs are active-low {g,f,e,d,c,b,a}: a 0 bit lights that segment.
`timescale 1ns/1ps
package segment7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/segment7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
// When oe_i is low, the output is the blank pattern.
`timescale 1ns/1ps
module segment7_hex_decoder
  import segment7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       oe_i,
  output logic [6:0] seg_o
);

  assign seg_o = oe_i ? HEX_GLYPH[nib_i] : SEG_BLANK;

endmodule

// File: rtl/segment7_hex_scanner.sv
// Multiplexed hex display scanner. Provides a prescaled digit scan, a frame-aligned
// pending-to-display load with an ack pulse, blink phase, and leading-zero blanking.
`timescale 1ns/1ps
module segment7_hex_scanner
  import segment7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  oe,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic                  ld,
  output logic                  ld_ack,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                phase_q, phase_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                ack_q, ack_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                boundary;
  logic [DIGITS-1:0]   sel;
  logic [DIGITS-1:0]   lead_zero;
  logic [4*DIGITS-1:0] disp_shift;
  logic [3:0]          nib;
  logic                lit;
  logic [6:0]          glyph;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    frame_d  = frame_q;
    phase_d  = phase_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ack_d    = boundary && pend_v_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (boundary) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
    // The old pending value is applied first; a coincident ld then re-arms pending.
    if (boundary && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (ld) begin
      pend_d   = hex;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    logic seen;
    seen      = 1'b0;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (disp_q[4*i +: 4] != 4'h0);
      lead_zero[i] = ~seen;
    end
  end

  always_comb begin
    sel        = DIGITS'(1) << idx_q;
    disp_shift = disp_q >> {idx_q, 2'b00};
    nib        = disp_shift[3:0];
    lit        = oe
                 && !(((blink & sel) != '0) && phase_q)
                 && !(lz_blank && (idx_q != '0) && ((lead_zero & sel) != '0));
    seg_d      = glyph;
    an_d       = ~sel;
  end

  segment7_hex_decoder u_dec (
    .nib_i (nib),
    .oe_i  (lit),
    .seg_o (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ack_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= ack_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign ld_ack = ack_q;

endmodule

// File: tb/tb_segment7_hex_scanner.sv
// Bench for segment7_hex_scanner: a cycle-count based model checked every cycle,
// plus directed loads, blanking and reset cases with literal expectations.
`timescale 1ns/1ps
module tb_segment7_hex_scanner;

  localparam int DIGITS       = 4;
  localparam int PRESCALE     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = PRESCALE * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oe = 1'b1;
  logic        ld = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] hex = 16'h0;
  logic [3:0]  blink = 4'h0;
  logic        ld_ack;
  logic [6:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [6:0] GL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pend_v = 1'b0;

  segment7_hex_scanner #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .hex(hex), .ld(ld), .ld_ack(ld_ack),
    .lz_blank(lz_blank), .blink(blink), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
    end
  endtask

  // Returns at the falling edge just before posedge number n after release.
  task automatic at_k(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL at_k got=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic load(input int n, input logic [15:0] v);
    at_k(n);
    hex = v;
    ld  = 1'b1;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  // Model: scan position, frame and phase follow from the number of edges since release.
  always @(posedge clk) begin
    int k, idx, ph;
    logic [15:0] upper;
    logic [3:0]  nb;
    logic        blank, bnd, e_ack;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    if (!rst_n) begin
      cyc      = 0;
      m_disp   = 16'h0;
      m_pend   = 16'h0;
      m_pend_v = 1'b0;
    end else begin
      k     = cyc;
      idx   = (k / PRESCALE) % DIGITS;
      ph    = ((k / FRAME) / BLINK_FRAMES) % 2;
      upper = m_disp >> (4 * idx);
      nb    = upper[3:0];
      blank = !oe || (blink[idx] && ph == 1) || (lz_blank && idx > 0 && upper == 16'h0);
      e_seg = blank ? 7'h7F : GL[nb];
      e_an  = ~(4'b0001 << idx);
      bnd   = (k % FRAME) == FRAME - 1;
      e_ack = bnd && m_pend_v;
      if (e_ack) begin
        m_disp   = m_pend;
        m_pend_v = 1'b0;
      end
      if (ld) begin
        m_pend   = hex;
        m_pend_v = 1'b1;
      end
      cyc++;
      #1;
      chk("seg", seg, e_seg);
      chk("an", an, e_an);
      chk("ld_ack", ld_ack, e_ack);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_ack", ld_ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    at_k(1);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'h40);
    at_k(5);
    chk("scan_an1", an, 4'b1101);

    load(37, 16'h12AF);
    at_k(47);
    chk("pre_bnd_seg", seg, 7'h40);
    chk("pre_bnd_ack", ld_ack, 1'b0);
    at_k(48);
    chk("ack_12af", ld_ack, 1'b1);
    at_k(49);
    chk("ack_pulse_end", ld_ack, 1'b0);
    chk("digit0_F", seg, 7'h0E);
    at_k(50);
    load(50, 16'h1111);
    at_k(53);
    chk("digit1_A", seg, 7'h08);

    load(55, 16'h2222);
    at_k(64);
    chk("ack_last_wins", ld_ack, 1'b1);
    at_k(65);
    chk("single_ack", ld_ack, 1'b0);
    chk("show_2", seg, 7'h24);

    load(79, 16'h3333);
    chk("no_ack_bnd_ld", ld_ack, 1'b0);
    at_k(81);
    chk("still_2", seg, 7'h24);
    at_k(96);
    chk("ack_deferred", ld_ack, 1'b1);
    at_k(97);
    chk("show_3", seg, 7'h30);

    load(100, 16'h4444);
    load(111, 16'h5555);
    at_k(112);
    chk("ack_old_pend", ld_ack, 1'b1);
    at_k(113);
    chk("show_4", seg, 7'h19);
    at_k(128);
    chk("ack_new_pend", ld_ack, 1'b1);
    at_k(129);
    chk("show_5", seg, 7'h12);

    at_k(130);
    lz_blank = 1'b1;
    load(130, 16'h0040);
    at_k(145);
    chk("lz_d0", seg, 7'h40);
    at_k(149);
    chk("lz_d1", seg, 7'h19);
    at_k(153);
    chk("lz_d2", seg, 7'h7F);
    at_k(157);
    chk("lz_d3", seg, 7'h7F);
    load(160, 16'h0000);
    at_k(177);
    chk("lz0_d0", seg, 7'h40);
    at_k(181);
    chk("lz0_d1", seg, 7'h7F);

    at_k(200);
    lz_blank = 1'b0;
    blink    = 4'b0010;
    at_k(225);
    chk("blink_d0", seg, 7'h40);
    at_k(229);
    chk("blink_d1_off", seg, 7'h7F);
    chk("blink_an", an, 4'b1101);
    at_k(261);
    chk("blink_d1_on", seg, 7'h40);

    at_k(270);
    oe = 1'b0;
    at_k(271);
    chk("oe_blank", seg, 7'h7F);
    at_k(272);
    chk("oe_an_scan", an, 4'b0111);
    at_k(280);
    oe    = 1'b1;
    blink = 4'h0;

    load(290, 16'h6666);
    at_k(295);
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_ack", ld_ack, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    at_k(17);
    chk("post_rst_ack", ld_ack, 1'b0);
    chk("post_rst_seg", seg, 7'h40);
    at_k(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segment7_hex_scanner.md
SEGMENT7_HEX_SCANNER -- requirements
Module: segment7_hex_scanner

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of multiplexed hex digits (1..8).
REQ-002 SHALL provide parameter PRESCALE, default 50000, clk cycles per digit slot (>=2).
REQ-003 SHALL provide parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 oe  input  1  1 = display enabled; 0 = all digits blank.
REQ-008 hex  input  4*DIGITS  value to display; nibble i drives digit i, digit 0 = hex[3:0].
REQ-009 ld  input  1  load request; samples hex into pending register.
REQ-010 ld_ack  output  1  one-cycle pulse when pending value becomes the displayed value.
REQ-011 lz_blank  input  1  1 = blank leading zero digits.
REQ-012 blink  input  DIGITS  per-digit blink enable.
REQ-013 seg  output  7  segment drive, active-low (0 = lit), glyph encoding identical to segment7_hex_decoder.
REQ-014 an  output  DIGITS  digit enable, one-hot active-low.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and assert internal tick on the cycle it equals PRESCALE-1, then wrap to 0.
REQ-016 On tick, digit index SHALL advance by 1, wrapping DIGITS-1 -> 0; a tick wrapping to 0 is the frame boundary.
REQ-017 ld=1 SHALL copy hex into pending register and set pend_v; ld while pend_v=1 SHALL overwrite (last wins), producing only one ld_ack.
REQ-018 At a frame boundary with pend_v=1 (registered value before that edge), display register SHALL take pending and pend_v SHALL clear; ld_ack SHALL be 1 in the following cycle only.
REQ-019 ld coincident with a frame-boundary tick SHALL land in pending and be applied at the next frame boundary; any older pending value SHALL be applied at the current boundary and is then replaced.
REQ-020 A frame counter SHALL count frame boundaries modulo BLINK_FRAMES and toggle blink phase on wrap; phase SHALL start 0.
REQ-021 Digit i SHALL be blank (seg = 7'h7F) when oe=0, or blink[i]=1 and phase=1, or lz_blank=1 and i>0 and display nibbles i..DIGITS-1 are all zero.
REQ-022 Digit 0 SHALL never be blanked by lz_blank.
REQ-023 seg and an SHALL be registered: one cycle latency from index/display change to outputs.
REQ-024 an SHALL hold ~(1<<index) even when the digit is blank; only seg blanks.
REQ-025 lz_blank, blink and oe SHALL act live, not deferred to a frame boundary.

Reset
REQ-026 While rst_n=0: prescaler 0, index 0, display 0, pending 0, pend_v 0, frame counter 0, phase 0, ld_ack 0, an all ones, seg 7'h7F.
REQ-027 Reset mid-frame or with pend_v=1 SHALL discard the pending value without ld_ack.
REQ-028 First rising edge after release SHALL drive an = ~1 and seg = glyph of digit 0 (value 0 -> "0").

Structure
REQ-029 Shared package segment7_pkg SHALL hold SEG_BLANK = 7'h7F and the hex glyph table used by segment7_hex_decoder.
REQ-030 Glyph lookup SHALL instantiate one segment7_hex_decoder on the selected nibble (oe tied to the computed not-blank term); no per-digit decoders.
REQ-031 Prescaler, index, frame/phase, pending/display handshake SHALL reside in this module; target 150-300 lines.

Verification (DIGITS=4, PRESCALE=4, BLINK_FRAMES=2)
REQ-032 Reset release, no ld: an cycles 1110,1101,1011,0111 every 4 clk; seg = glyph "0" throughout; ld_ack never 1.
REQ-033 ld=1 with hex=16'h12AF at cycle 5 -> display changes only after frame boundary (cycle 15); single ld_ack pulse at cycle 16; digits show F,A,2,1.
REQ-034 Two ld (16'h1111, then 16'h2222) in one frame -> one ld_ack, 16'h2222 displayed; ld on boundary cycle -> applied one frame (16 clk) later.
REQ-035 hex=16'h0040, lz_blank=1 -> digits 3,2 seg=7'h7F, digit 1 "4", digit 0 "0"; hex=16'h0000 -> only digit 0 lit.
REQ-036 blink=4'b0010 -> digit 1 blank in frames 2,3, lit in frames 0,1, repeating; oe=0 -> all seg 7'h7F next cycle, an keeps scanning.
REQ-037 rst_n asserted mid-frame with pend_v=1 -> outputs return to reset values asynchronously; no ld_ack after release; display 0.
